// File: rtl/wb_ram_pkg.sv
// wb_ram_pkg: shared types and widths for the Wishbone RAM responder.
package wb_ram_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam int CNT_W = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W = 4;
endpackage

// File: rtl/wb_ram_array.sv
// wb_ram_array: single-port synchronous word RAM with byte write enables.
module wb_ram_array import wb_ram_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        addr,
  input  logic [WB_SEL_W-1:0]  be,
  input  logic [WB_DATA_W-1:0] wdata,
  output logic [WB_DATA_W-1:0] rdata
);
  logic [WB_DATA_W-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int b = 0; b < WB_SEL_W; b++)
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/wb_ram_responder.sv
// wb_ram_responder: Wishbone RAM slave acking each request after a programmable latency.
// WB_RAM_PREFETCH_EN adds a one-word next-address read buffer that answers hits in one cycle.
module wb_ram_responder import wb_ram_pkg::*; #(
  parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [WB_SEL_W-1:0]  wbs_sel_i,
  input  logic [WB_DATA_W-1:0] wbs_dat_i,
  input  logic [31:0]          wbs_adr_i,
  output logic                 wbs_ack_o,
  output logic [WB_DATA_W-1:0] wbs_dat_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state;
  logic [CNT_W-1:0] cnt, lat_i;
  logic we_q, oob_q, hit_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic [WB_DATA_W-1:0] dat_q, dat_hold, ram_q, pf_rd, ack_data;
  logic [AW-1:0] idx_q, idx_i, ram_idx;
  logic [31:0] off_i;
  logic req, in_rng_i, hit, pf_go, use_in, commit, c_we, c_rng, ram_we, ram_re;
  assign off_i = wbs_adr_i - ADDR_BASE;
  assign in_rng_i = off_i < 32'(4 * DEPTH_WORDS);
  assign idx_i = off_i[AW+1:2];
  assign req = wbs_stb_i & wbs_cyc_i;
  assign lat_i = hit ? CNT_W'(1) : wbs_we_i ? CNT_W'(WR_LATENCY) : CNT_W'(RD_LATENCY);
  // The RAM is accessed on the edge that enters ACK; in IDLE that edge still sees the live bus.
  assign use_in = state == IDLE;
  assign commit = use_in ? req & (lat_i == CNT_W'(1)) : (state == WAIT) & wbs_cyc_i & (cnt == CNT_W'(2));
  assign c_we = use_in ? wbs_we_i : we_q;
  assign c_rng = use_in ? in_rng_i : !oob_q;
  assign ram_we = commit & c_rng & c_we;
  assign ram_re = (commit & c_rng & !c_we & !(use_in & hit)) | pf_go;
  assign ram_idx = pf_go ? idx_q + 1'b1 : use_in ? idx_i : idx_q;
  assign ack_data = oob_q ? '0 : hit_q ? pf_rd : ram_q;
  assign wbs_dat_o = (wbs_ack_o & !we_q) ? ack_data : dat_hold;

  wb_ram_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(wb_clk_i),
    .we(ram_we),
    .re(ram_re),
    .addr(ram_idx),
    .be(use_in ? wbs_sel_i : sel_q),
    .wdata(use_in ? wbs_dat_i : dat_q),
    .rdata(ram_q)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      wbs_ack_o <= 1'b0;
      dat_hold <= '0;
      we_q <= 1'b0;
      oob_q <= 1'b0;
      hit_q <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= (lat_i == CNT_W'(1)) ? ACK : WAIT;
          wbs_ack_o <= lat_i == CNT_W'(1);
          cnt <= lat_i;
          we_q <= wbs_we_i;
          sel_q <= wbs_sel_i;
          dat_q <= wbs_dat_i;
          idx_q <= idx_i;
          oob_q <= !in_rng_i;
          hit_q <= hit;
        end
        WAIT: if (!wbs_cyc_i) state <= IDLE;
        else begin
          cnt <= cnt - 1'b1;
          state <= (cnt == CNT_W'(2)) ? ACK : WAIT;
          wbs_ack_o <= cnt == CNT_W'(2);
        end
        default: begin
          state <= IDLE;
          wbs_ack_o <= 1'b0;
          if (!we_q) dat_hold <= ack_data;
        end
      endcase
    end
  end

`ifdef WB_RAM_PREFETCH_EN
  logic pf_valid, pf_pend, rd_done;
  logic [AW-1:0] pf_idx;
  logic [WB_DATA_W-1:0] pf_data;
  assign rd_done = (state == ACK) & !we_q & !oob_q;
  assign pf_go = rd_done & !(&idx_q);
  // A hit may land while the prefetched word is still in the RAM output register.
  assign hit = req & !wbs_we_i & in_rng_i & (pf_valid | pf_pend) & (idx_i == pf_idx);
  assign pf_rd = pf_data;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pf_valid <= 1'b0;
      pf_pend <= 1'b0;
      pf_idx <= '0;
      pf_data <= '0;
    end else begin
      if (pf_pend) pf_data <= ram_q;
      if (rd_done) pf_idx <= idx_q + 1'b1;
      pf_pend <= pf_go;
      pf_valid <= (rd_done | (ram_we & (ram_idx == pf_idx))) ? 1'b0 : pf_pend | pf_valid;
    end
  end
`else
  assign hit = 1'b0;
  assign pf_go = 1'b0;
  assign pf_rd = '0;
`endif
endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: randomized scoreboard bench for wb_ram_responder against a word-array model.
module tb_wb_ram_responder;
  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam int DEPTH = 16;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 1;

  typedef struct {
    bit rd;
    logic [31:0] dat;
    int edge_n;
  } exp_t;

  logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0, ack;
  logic [3:0] sel = 0;
  logic [31:0] dat_i = 0, adr = 0, dat_o;
  exp_t exp_q[$];
  exp_t e_mon;
  int tests = 0, fails = 0, edges = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] last_rd = 0;
`ifdef WB_RAM_PREFETCH_EN
  bit pf_valid = 0;
  int pf_idx = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  wb_ram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] o = a - BASE;
    return o < 32'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o = (a - BASE) >> 2;
    return int'(o % DEPTH);
  endfunction

  // Monitor: every ack pops one expectation; between acks the read data must hold.
  always @(negedge clk) if (!rst) begin
    if (ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_ack: got ack=1 expected ack=0 at edge %0d", edges);
      end else begin
        e_mon = exp_q.pop_front();
        chk("ack_edge", 32'(edges), 32'(e_mon.edge_n));
        if (e_mon.rd) begin
          chk("rd_data", dat_o, e_mon.dat);
          last_rd = e_mon.dat;
        end else chk("dat_hold_wr", dat_o, last_rd);
      end
    end else chk("dat_hold", dat_o, last_rd);
  end

  // Drives one request; lat returns 0 when the request is to be aborted.
  task automatic start(input bit w, input logic [3:0] s, input logic [31:0] d, input logic [31:0] a,
                       input bit ab, output int lat);
    exp_t e;
    bit rng = in_rng(a);
    int idx = widx(a);
    lat = w ? WR_LAT : RD_LAT;
`ifdef WB_RAM_PREFETCH_EN
    if (!w && rng && pf_valid && pf_idx == idx) lat = 1;
`endif
    @(negedge clk);
    stb = 1; cyc = 1; we = w; sel = s; dat_i = d; adr = a;
    if (ab && lat > 1) begin
      lat = 0;
      return;
    end
    e.rd = !w;
    e.dat = (!w && rng) ? mem[idx] : 32'h0;
    e.edge_n = edges + lat;
    exp_q.push_back(e);
    if (w && rng) begin
      for (int b = 0; b < 4; b++) if (s[b]) mem[idx][8*b +: 8] = d[8*b +: 8];
`ifdef WB_RAM_PREFETCH_EN
      if (pf_idx == idx) pf_valid = 0;
`endif
    end
`ifdef WB_RAM_PREFETCH_EN
    if (!w && rng) begin
      pf_valid = idx < DEPTH - 1;
      pf_idx = idx + 1;
    end
`endif
  endtask

  task automatic finish_xfer(input int lat, input bit glitch);
    if (lat == 0) begin
      @(negedge clk);
      cyc = 0; stb = 0;
      repeat (RD_LAT + 2) @(negedge clk);
      return;
    end
    if (glitch && lat > 2) begin
      @(negedge clk); stb = 0;
      @(negedge clk); stb = 1;
    end
    for (int n = 0; n < 20 && !ack; n++) @(negedge clk);
    if (!ack) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got no ack expected ack within 20 cycles (t=%0t)", $time);
      exp_q.delete();
    end
    @(posedge clk);
    #1 stb = 0; cyc = 0;
  endtask

  task automatic xfer(input bit w, input logic [3:0] s, input logic [31:0] d, input logic [31:0] a,
                      input bit ab = 0, input bit gl = 0);
    int lat;
    start(w, s, d, a, ab, lat);
    finish_xfer(lat, gl);
  endtask

  task automatic do_reset();
    #2 rst = 1;
    last_rd = 0;
    exp_q.delete();
`ifdef WB_RAM_PREFETCH_EN
    pf_valid = 0;
`endif
    #1 chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    stb = 0; cyc = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int lat, r;
    logic [31:0] a, prev_a;
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'b0, ack}, 32'h0);
    chk("reset_dat", dat_o, 32'h0);
    rst = 0;
    for (int i = 0; i < DEPTH; i++) xfer(1, 4'hF, $urandom, BASE + 32'(4 * i));
    xfer(1, 4'hF, 32'hDEAD_BEEF, BASE + 8);
    xfer(0, 4'hF, 0, BASE + 8);
    xfer(1, 4'b0010, 32'h0000_AA00, BASE + 8);
    xfer(0, 4'hF, 0, BASE + 8);
    xfer(0, 4'hF, 0, BASE + 20, 1);
    xfer(0, 4'hF, 0, BASE + 32'(4 * DEPTH));
    xfer(1, 4'hF, 32'h1234_5678, BASE + 32'(4 * DEPTH));
    xfer(0, 4'hF, 0, BASE);
    xfer(0, 4'hF, 0, BASE - 4);
    xfer(0, 4'hF, 0, BASE + 32'(4 * (DEPTH - 1)));
    xfer(0, 4'hF, 0, BASE);
    xfer(0, 4'hF, 0, BASE + 4);
    xfer(1, 4'hF, 32'hCAFE_F00D, BASE + 8);
    xfer(0, 4'hF, 0, BASE + 8 + 3, 0, 1);
    start(0, 4'hF, 0, BASE, 0, lat);
    @(negedge clk);
    do_reset();
    xfer(0, 4'hF, 0, BASE + 12);
    start(0, 4'hF, 0, BASE + 8, 0, lat);
    for (int n = 0; n < 20 && !ack; n++) @(negedge clk);
    do_reset();
    xfer(0, 4'hF, 0, BASE + 8);
    prev_a = BASE;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        1: a = $urandom;
        2, 3: a = prev_a + 4;
        default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      endcase
      prev_a = a;
      xfer($urandom_range(0, 2) == 0, 4'($urandom), $urandom, a, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
